// File: rtl/draw_bug_pkg.sv
// Shared VGA constants for the sprite overlay: sprite geometry, colour width,
// default transparent colour and the width of the packed timing bus.
package draw_bug_pkg;

  localparam int XPOS_W_DEF = 11;
  localparam int SPRITE_W   = 64;
  localparam int SPRITE_H   = 64;
  localparam int RGB_W      = 12;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'hF0F;

  // Timing bus = hcount + vcount + hsync + vsync + hblnk + vblnk
  function automatic int timing_w(input int xw);
    return 2 * xw + 4;
  endfunction

  localparam int TIMING_W = timing_w(XPOS_W_DEF);

endpackage

// File: rtl/draw_bug_if.sv
// Pixel-stream bundle between timing generator / sprite ROM (master) and the
// sprite overlay (slave).
interface draw_bug_if
  import draw_bug_pkg::*;
#(
  parameter int XPOS_W = XPOS_W_DEF
);

  logic [XPOS_W-1:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic              hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic              hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [XPOS_W-1:0] xpos, ypos;
  logic [RGB_W-1:0]  rgb_in, rgb_out;
  logic [11:0]       rom_addr;
  logic [RGB_W-1:0]  rom_rgb;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, xpos, ypos, rom_rgb,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    input  rgb_out, rom_addr
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, xpos, ypos, rom_rgb,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
    output rgb_out, rom_addr
  );

endinterface

// File: rtl/draw_bug_delay.sv
// Fixed-latency shift register: dout is din delayed by DEPTH clocks, reset to 0.
module draw_bug_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_r [DEPTH];

  // Shift chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/draw_bug.sv
// Sprite overlay: box test and ROM addressing in stage 1, ROM read in stage 2,
// key-colour compositing in stage 3; timing passes through a 3-clock delay.
module draw_bug
  import draw_bug_pkg::*;
#(
  parameter int               XPOS_W    = XPOS_W_DEF,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input logic       clk,
  input logic       rst_n,
  draw_bug_if.slave bus
);

  localparam int TW = timing_w(XPOS_W);

  logic              vblnk_prev_r;
  logic [XPOS_W-1:0] xpos_l_r, ypos_l_r;
  logic              vblnk_rise_s;
  logic [XPOS_W:0]   hc_s, vc_s, x0_s, y0_s, x1_s, y1_s;
  logic              in_box_s;
  logic [5:0]        dx_s, dy_s;
  logic              in_box_r, in_box_d_r;
  logic [11:0]       rom_addr_r;
  logic [TW-1:0]     timing_s, timing_d_s;
  logic [RGB_W-1:0]  rgb_d2_s, pix_s, rgb_out_r;
  logic              hblnk_d2_s, vblnk_d2_s;

  assign vblnk_rise_s = bus.vblnk_in & ~vblnk_prev_r;

  // Sprite position is only taken at frame start so a frame is never torn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_r <= 1'b0;
      xpos_l_r     <= '0;
      ypos_l_r     <= '0;
    end else begin
      vblnk_prev_r <= bus.vblnk_in;
      if (vblnk_rise_s) begin
        xpos_l_r <= bus.xpos;
        ypos_l_r <= bus.ypos;
      end else begin
        xpos_l_r <= xpos_l_r;
        ypos_l_r <= ypos_l_r;
      end
    end
  end

  // Box test one bit wider than the counts so the right/bottom edge cannot wrap
  always_comb begin
    hc_s     = {1'b0, bus.hcount_in};
    vc_s     = {1'b0, bus.vcount_in};
    x0_s     = {1'b0, xpos_l_r};
    y0_s     = {1'b0, ypos_l_r};
    x1_s     = x0_s + (XPOS_W+1)'(SPRITE_W);
    y1_s     = y0_s + (XPOS_W+1)'(SPRITE_H);
    in_box_s = (hc_s >= x0_s) && (hc_s < x1_s) && (vc_s >= y0_s) && (vc_s < y1_s);
    dx_s     = 6'(bus.hcount_in - xpos_l_r);
    dy_s     = 6'(bus.vcount_in - ypos_l_r);
  end

  // Stage 1 and 2 sprite-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_r   <= 1'b0;
      in_box_d_r <= 1'b0;
      rom_addr_r <= 12'h000;
    end else begin
      in_box_r   <= in_box_s;
      in_box_d_r <= in_box_r;
      rom_addr_r <= in_box_s ? {dy_s, dx_s} : 12'h000;
    end
  end

  assign timing_s = {bus.hcount_in, bus.vcount_in, bus.hsync_in, bus.vsync_in,
                     bus.hblnk_in, bus.vblnk_in};

  draw_bug_delay #(.WIDTH(TW), .DEPTH(3)) u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (timing_s),
    .dout  (timing_d_s)
  );

  // Background and blanking only need to reach the compositing stage
  draw_bug_delay #(.WIDTH(RGB_W + 2), .DEPTH(2)) u_bg (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({bus.rgb_in, bus.hblnk_in, bus.vblnk_in}),
    .dout  ({rgb_d2_s, hblnk_d2_s, vblnk_d2_s})
  );

  always_comb begin
    pix_s = rgb_d2_s;
    if (in_box_d_r && !hblnk_d2_s && !vblnk_d2_s && (bus.rom_rgb != KEY_COLOR)) begin
      pix_s = bus.rom_rgb;
    end else begin
      pix_s = rgb_d2_s;
    end
  end

  // Stage 3 compositing register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_out_r <= '0;
    else        rgb_out_r <= pix_s;
  end

  assign bus.rom_addr = rom_addr_r;
  assign bus.rgb_out  = rgb_out_r;
  assign {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
          bus.hblnk_out, bus.vblnk_out} = timing_d_s;

endmodule

// File: doc/draw_bug.md
DRAW_BUG -- requirements
Module: draw_bug

Interface
REQ-001 Parameter XPOS_W, default 11: width of hcount, vcount, xpos and ypos.
REQ-002 Parameter KEY_COLOR, default 12'hF0F: sprite RGB value treated as transparent.
REQ-003 clk  input  1: pixel clock; all state updates on rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 hcount_in, vcount_in  input  XPOS_W each: current pixel coordinates from the timing generator.
REQ-006 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each: timing strobes aligned with the counts.
REQ-007 rgb_in  input  12: background pixel, {R,G,B} 4 bits each.
REQ-008 xpos, ypos  input  XPOS_W each: requested sprite top-left corner, may change at any cycle.
REQ-009 rom_addr  output  12: sprite ROM address {dy[5:0], dx[5:0]}.
REQ-010 rom_rgb  input  12: sprite ROM data; valid exactly one clk after rom_addr.
REQ-011 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  output: input timing signals delayed 3 clk.
REQ-012 rgb_out  output  12: composited pixel, aligned with the delayed timing.

Function
REQ-013 xpos_l/ypos_l SHALL load xpos/ypos only on the cycle a rising edge of vblnk_in is detected (vblnk_in=1, registered previous vblnk_in=0); otherwise hold.
REQ-014 Stage 1 (T+1): in_box SHALL be registered as hcount_in >= xpos_l AND hcount_in < xpos_l+64 AND vcount_in >= ypos_l AND vcount_in < ypos_l+64, evaluated at XPOS_W+1 bits so xpos_l+64 never wraps.
REQ-015 Stage 1: rom_addr SHALL be registered as {(vcount_in-ypos_l)[5:0], (hcount_in-xpos_l)[5:0]} when in_box, else 12'h000.
REQ-016 Stage 2 (T+2): rom_rgb valid; timing signals, rgb_in and in_box carried through a second register stage.
REQ-017 Stage 3 (T+3): rgb_out SHALL equal rom_rgb when delayed in_box=1, delayed hblnk=0, delayed vblnk=0 and rom_rgb != KEY_COLOR; otherwise delayed rgb_in.
REQ-018 All timing outputs SHALL be exactly 3-cycle delayed copies of their inputs, with no gaps or reordering.
REQ-019 xpos/ypos changes during active video SHALL NOT affect the frame in progress.
REQ-020 A sprite partially off the right or bottom edge SHALL be clipped by the timing counts; no addresses wrap into the visible area.
REQ-021 A vblnk rising edge and an xpos change in the same cycle SHALL latch the new xpos.

Reset
REQ-022 While rst_n=0, all pipeline registers, rom_addr, rgb_out, timing outputs, xpos_l, ypos_l and previous vblnk SHALL be 0.
REQ-023 Reset release mid-frame SHALL produce background-only output until the first vblnk rising edge, since in_box is evaluated at position (0,0) only.
REQ-024 Outputs SHALL be valid 3 clk after rst_n deasserts.

Structure
REQ-025 The shared VGA package SHALL hold SPRITE_W=64, SPRITE_H=64, the timing bus width, and KEY_COLOR default.
REQ-026 One sub-module, delay (parameterised width and depth), SHALL implement the 3-stage timing/rgb pipeline; box test and compositing remain in draw_bug.

Verification
REQ-027 xpos=100, ypos=50 latched at vblnk; hcount=100, vcount=50 -> rom_addr=12'h000 at T+1, rgb_out=rom_rgb at T+3.
REQ-028 hcount=163, vcount=113 -> rom_addr=12'hFFF; hcount=164 -> in_box=0, rgb_out=rgb_in.
REQ-029 rom_rgb=12'hF0F inside box -> rgb_out=rgb_in; rom_rgb=12'h123 -> rgb_out=12'h123.
REQ-030 xpos changed from 100 to 300 mid-frame -> sprite remains at 100 until next vblnk rising edge, then at 300.
REQ-031 xpos=1000 on 1024-wide line -> columns 1000..1023 drawn, no pixels at hcount 0..39 of the same or next line.
REQ-032 rst_n pulsed low mid-line -> all outputs 0 within the same cycle, timing copies resume 3 clk after release.
